// File: rtl/arb_pkg.sv
// Shared arbiter definitions: burst FSM state encoding and client-index width helper.
package arb_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   // Smallest index width able to address n clients, never less than one bit.
   function automatic int arb_iw(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/arb_skid_buf.sv
// Two-entry output skid buffer; entry 0 is always the head presented downstream.
module arb_skid_buf #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         init_n,
   input  logic         push_i,
   input  logic [W-1:0] din_i,
   output logic         free_o,
   output logic         valid_o,
   input  logic         ready_i,
   output logic [W-1:0] dout_o
);

   logic [1:0]   cnt_q, cnt_d;
   logic [W-1:0] e0_q, e0_d;
   logic [W-1:0] e1_q, e1_d;
   logic         pop;

   assign pop     = ready_i && (cnt_q != 2'd0);
   assign valid_o = (cnt_q != 2'd0);
   // A full buffer still accepts when the head leaves in the same cycle.
   assign free_o  = (cnt_q != 2'd2) || ready_i;
   assign dout_o  = e0_q;

   always_comb begin
      cnt_d = cnt_q;
      e0_d  = e0_q;
      e1_d  = e1_q;
      case (cnt_q)
         2'd0: begin
            if (push_i) begin
               e0_d  = din_i;
               cnt_d = 2'd1;
            end
         end
         2'd1: begin
            if (push_i && pop) begin
               e0_d = din_i;
            end else if (push_i) begin
               e1_d  = din_i;
               cnt_d = 2'd2;
            end else if (pop) begin
               cnt_d = 2'd0;
            end
         end
         default: begin
            if (pop) begin
               e0_d = e1_q;
               if (push_i) e1_d = din_i;
               else        cnt_d = 2'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 2'd0;
         e0_q  <= '0;
         e1_q  <= '0;
      end else if (!init_n) begin
         cnt_q <= 2'd0;
         e0_q  <= '0;
         e1_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         e0_q  <= e0_d;
         e1_q  <= e1_d;
      end
   end

endmodule

// File: rtl/arb_grant_mux.sv
// Grant-driven burst multiplexer: locks onto one arbiter winner until its last beat.
// Define ARB_GRANT_MUX_TIMEOUT_EN to abort bursts whose owner stalls for TMO cycles.
module arb_grant_mux
   import arb_pkg::*;
#(
   parameter  int N   = 4,
   parameter  int DW  = 32,
   parameter  int TMO = 16,
   localparam int IW  = arb_iw(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          init_n,
   input  logic          granted,
   input  logic [N-1:0]  grant,
   input  logic [N-1:0]  cl_valid,
   input  logic [N-1:0]  cl_last,
   input  logic [N*DW-1:0] cl_data,
   output logic [N-1:0]  cl_ready,
   output logic          arb_enable,
   output logic [N-1:0]  arb_mask,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic [IW-1:0] out_src,
   output logic          out_last,
   output logic          err_onehot,
   output logic          tmo_pulse
);

   localparam int BW = DW + IW + 1;

   if (N < 2 || N > 32 || TMO < 2 || TMO > 255) begin : g_bad_param
      $error("arb_grant_mux: parameter out of range");
   end

   arb_state_e    state_q, state_d;
   logic [IW-1:0] owner_q, owner_d;
   logic [IW-1:0] grant_idx;
   logic          err_q, err_d;
   logic          grant_ok;
   logic          own_valid, own_last;
   logic [DW-1:0] own_data;
   logic          buf_free, xfer, abort;
   logic [BW-1:0] buf_din, buf_dout;

   assign grant_ok = (grant != '0) && ((grant & (grant - N'(1))) == '0);

   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (grant[i]) grant_idx = IW'(i);
      end
   end

   always_comb begin
      own_valid = 1'b0;
      own_last  = 1'b0;
      own_data  = '0;
      for (int i = 0; i < N; i++) begin
         if (owner_q == IW'(i)) begin
            own_valid = cl_valid[i];
            own_last  = cl_last[i];
            own_data  = cl_data[i*DW +: DW];
         end
      end
   end

   assign xfer = (state_q == BURST) && own_valid && buf_free;

`ifdef ARB_GRANT_MUX_TIMEOUT_EN
   logic [7:0] tcnt_q, tcnt_d;
   logic       tmo_q;

   // Counts owner idle cycles only; a valid beat held off by a full buffer is not a stall.
   always_comb begin
      tcnt_d = tcnt_q;
      abort  = 1'b0;
      if (state_q != BURST) begin
         tcnt_d = '0;
      end else if (xfer) begin
         tcnt_d = '0;
      end else if (!own_valid) begin
         if (tcnt_q == 8'(TMO - 1)) begin
            abort  = 1'b1;
            tcnt_d = '0;
         end else begin
            tcnt_d = tcnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tcnt_q <= '0;
         tmo_q  <= 1'b0;
      end else if (!init_n) begin
         tcnt_q <= '0;
         tmo_q  <= 1'b0;
      end else begin
         tcnt_q <= tcnt_d;
         tmo_q  <= abort;
      end
   end

   assign tmo_pulse = tmo_q;
`else
   assign abort     = 1'b0;
   assign tmo_pulse = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (granted) begin
               if (grant_ok) begin
                  state_d = BURST;
                  owner_d = grant_idx;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         default: begin
            if ((xfer && own_last) || abort) state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         owner_q <= '0;
         err_q   <= 1'b0;
      end else if (!init_n) begin
         state_q <= IDLE;
         owner_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         err_q   <= err_d;
      end
   end

   // The arbiter stays disabled for as long as reset is held.
   assign arb_enable = rst_n && (state_q == IDLE);
   assign err_onehot = err_q;

   always_comb begin
      arb_mask = '0;
      cl_ready = '0;
      if (state_q == BURST) begin
         for (int i = 0; i < N; i++) begin
            arb_mask[i] = (owner_q != IW'(i));
            cl_ready[i] = (owner_q == IW'(i)) && buf_free;
         end
      end
   end

   assign buf_din = {own_last, owner_q, own_data};

   arb_skid_buf #(
      .W (BW)
   ) u_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .init_n  (init_n),
      .push_i  (xfer),
      .din_i   (buf_din),
      .free_o  (buf_free),
      .valid_o (out_valid),
      .ready_i (out_ready),
      .dout_o  (buf_dout)
   );

   assign {out_last, out_src, out_data} = buf_dout;

endmodule

// File: tb/tb_arb_grant_mux.sv
// Table-driven and scoreboarded bench for arb_grant_mux (N=4, DW=32, TMO=4).
module tb_arb_grant_mux;

   localparam int N   = 4;
   localparam int DW  = 32;
   localparam int TMO = 4;
   localparam int IW  = 2;

   logic          clk = 1'b0;
   logic          rst_n, init_n, granted, out_ready;
   logic [N-1:0]  grant, cl_valid, cl_last;
   logic [N*DW-1:0] cl_data;
   logic [N-1:0]  cl_ready, arb_mask;
   logic          arb_enable, out_valid, out_last, err_onehot, tmo_pulse;
   logic [DW-1:0] out_data;
   logic [IW-1:0] out_src;

   arb_grant_mux #(.N(N), .DW(DW), .TMO(TMO)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .init_n     (init_n),
      .granted    (granted),
      .grant      (grant),
      .cl_valid   (cl_valid),
      .cl_last    (cl_last),
      .cl_data    (cl_data),
      .cl_ready   (cl_ready),
      .arb_enable (arb_enable),
      .arb_mask   (arb_mask),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_src    (out_src),
      .out_last   (out_last),
      .err_onehot (err_onehot),
      .tmo_pulse  (tmo_pulse)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [IW-1:0] src;
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   typedef struct {
      logic         granted;
      logic [N-1:0] grant;
      logic [N-1:0] mask;
      logic         en;
      logic [N-1:0] rdy;
      logic         err;
   } vec_t;

   beat_t sbq[$];
   int    checks   = 0;
   int    failures = 0;
   int    cur_own  = 0;
   logic  acc;
   vec_t  vt[7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Scoreboard step, evaluated at the falling edge with inputs stable.
   task automatic sb_step();
      beat_t b, e;
      acc = 1'b0;
      if (!rst_n || !init_n) begin
         sbq.delete();
      end else begin
         chk("ready_onehot", 64'($countones(cl_ready) <= 1), 64'(1));
         if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
               chk("sb_unexpected_beat", 64'(out_data), 64'hDEAD_0000_0000);
            end else begin
               e = sbq.pop_front();
               b.src  = out_src;
               b.data = out_data;
               b.last = out_last;
               chk("sb_beat", 64'(b), 64'(e));
            end
         end
         if (cl_valid[cur_own] && cl_ready[cur_own]) begin
            acc    = 1'b1;
            e.src  = IW'(cur_own);
            e.data = cl_data[cur_own*DW +: DW];
            e.last = cl_last[cur_own];
            sbq.push_back(e);
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      sb_step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_init();
      init_n = 1'b0;
      tick();
      init_n = 1'b1;
   endtask

   task automatic grant_to(input int own);
      cur_own = own;
      granted = 1'b1;
      grant   = N'(1) << own;
      tick();
      granted = 1'b0;
      grant   = '0;
   endtask

   task automatic drive_burst(input int own, input int nb, input logic [DW-1:0] base, input int hold);
      int k = 0;
      int c = 0;
      cur_own = own;
      while (k < nb && c < 100) begin
         cl_valid = N'(1) << own;
         cl_last  = (k == nb - 1) ? (N'(1) << own) : '0;
         cl_data  = '0;
         cl_data[own*DW +: DW] = base + DW'(k);
         out_ready = (c >= hold);
         #1;
         if (hold > 2 && c == hold - 1) begin
            chk("stall_accepted", 64'(k), 64'(2));
            chk("stall_cl_ready", 64'(cl_ready), 64'(0));
            chk("stall_out_valid", 64'(out_valid), 64'(1));
         end
         tick();
         if (acc) k++;
         c++;
      end
      chk("burst_complete", 64'(k), 64'(nb));
      cl_valid  = '0;
      cl_last   = '0;
      out_ready = 1'b1;
   endtask

   task automatic drain();
      int c = 0;
      out_ready = 1'b1;
      while ((sbq.size() != 0 || out_valid) && c < 20) begin
         tick();
         c++;
      end
      chk("drain_queue_empty", 64'(sbq.size()), 64'(0));
      chk("drain_out_valid", 64'(out_valid), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{1'b1, 4'b0001, 4'b1110, 1'b0, 4'b0001, 1'b0};
      vt[1] = '{1'b1, 4'b1000, 4'b0111, 1'b0, 4'b1000, 1'b0};
      vt[2] = '{1'b1, 4'b0110, 4'b0000, 1'b1, 4'b0000, 1'b1};
      vt[3] = '{1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1};
      vt[4] = '{1'b0, 4'b0100, 4'b0000, 1'b1, 4'b0000, 1'b0};
      vt[5] = '{1'b1, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1};
      vt[6] = '{1'b1, 4'b0100, 4'b1011, 1'b0, 4'b0100, 1'b0};

      rst_n = 1'b0; init_n = 1'b1; granted = 1'b0; grant = '0;
      cl_valid = '1; cl_last = '0; cl_data = '0; out_ready = 1'b1;
      tick();
      tick();
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_out_data", 64'(out_data), 64'(0));
      chk("rst_out_src", 64'(out_src), 64'(0));
      chk("rst_out_last", 64'(out_last), 64'(0));
      chk("rst_cl_ready", 64'(cl_ready), 64'(0));
      chk("rst_arb_mask", 64'(arb_mask), 64'(0));
      chk("rst_arb_enable", 64'(arb_enable), 64'(0));
      chk("rst_err", 64'(err_onehot), 64'(0));
      chk("rst_tmo", 64'(tmo_pulse), 64'(0));
      cl_valid = '0;
      rst_n = 1'b1;
      #1;
      chk("idle_arb_enable", 64'(arb_enable), 64'(1));
      chk("idle_cl_ready", 64'(cl_ready), 64'(0));

      // Grant acceptance table: each vector starts from a fresh init.
      for (int i = 0; i < 7; i++) begin
         do_init();
         granted = vt[i].granted;
         grant   = vt[i].grant;
         tick();
         granted = 1'b0;
         grant   = '0;
         #1;
         chk("tbl_arb_mask", 64'(arb_mask), 64'(vt[i].mask));
         chk("tbl_arb_enable", 64'(arb_enable), 64'(vt[i].en));
         chk("tbl_cl_ready", 64'(cl_ready), 64'(vt[i].rdy));
         chk("tbl_err_onehot", 64'(err_onehot), 64'(vt[i].err));
      end
      do_init();

      // Three-beat burst from client 2 at full rate.
      out_ready = 1'b1;
      grant_to(2);
      cl_valid = 4'b0100; cl_last = '0; cl_data = '0;
      cl_data[2*DW +: DW] = 32'hD000_0000;
      #1;
      chk("b2_arb_mask", 64'(arb_mask), 64'(4'b1011));
      chk("b2_arb_enable", 64'(arb_enable), 64'(0));
      chk("b2_cl_ready", 64'(cl_ready), 64'(4'b0100));
      chk("b2_empty_before", 64'(out_valid), 64'(0));
      tick();
      cl_data[2*DW +: DW] = 32'hD000_0001;
      #1;
      chk("b2_d0_valid", 64'(out_valid), 64'(1));
      chk("b2_d0_src", 64'(out_src), 64'(2));
      chk("b2_d0_data", 64'(out_data), 64'(32'hD000_0000));
      tick();
      cl_data[2*DW +: DW] = 32'hD000_0002;
      cl_last = 4'b0100;
      #1;
      chk("b2_d1_data", 64'(out_data), 64'(32'hD000_0001));
      chk("b2_mid_mask", 64'(arb_mask), 64'(4'b1011));
      tick();
      cl_valid = '0; cl_last = '0;
      #1;
      chk("b2_d2_data", 64'(out_data), 64'(32'hD000_0002));
      chk("b2_d2_last", 64'(out_last), 64'(1));
      chk("b2_idle_enable", 64'(arb_enable), 64'(1));
      chk("b2_idle_mask", 64'(arb_mask), 64'(0));
      tick();
      #1;
      chk("b2_out_empty", 64'(out_valid), 64'(0));

      // Client 1 burst with downstream stalled for 5 cycles.
      grant_to(1);
      drive_burst(1, 4, 32'h1100_0000, 5);
      drain();

      // Re-initialise with two beats held in the buffer.
      grant_to(3);
      out_ready = 1'b0;
      cl_valid = 4'b1000; cl_last = '0; cl_data = '0;
      cl_data[3*DW +: DW] = 32'h3300_0000;
      tick();
      cl_data[3*DW +: DW] = 32'h3300_0001;
      tick();
      #1;
      chk("init_pre_valid", 64'(out_valid), 64'(1));
      chk("init_pre_ready", 64'(cl_ready), 64'(0));
      do_init();
      cl_valid = '0;
      #1;
      chk("init_out_valid", 64'(out_valid), 64'(0));
      chk("init_arb_mask", 64'(arb_mask), 64'(0));
      chk("init_arb_enable", 64'(arb_enable), 64'(1));
      chk("init_out_data", 64'(out_data), 64'(0));
      out_ready = 1'b1;

      // Back-to-back bursts, client 0 then client 3.
      grant_to(0);
      drive_burst(0, 3, 32'h0A00_0000, 0);
      grant_to(3);
      drive_burst(3, 2, 32'h3A00_0000, 0);
      drain();

      // Owner stalls mid-burst after one beat.
      grant_to(1);
      cl_valid = 4'b0010; cl_last = '0; cl_data = '0;
      cl_data[1*DW +: DW] = 32'h5500_0000;
      tick();
      cl_valid = '0;
`ifdef ARB_GRANT_MUX_TIMEOUT_EN
      for (int s = 1; s <= 4; s++) begin
         tick();
         #1;
         if (s < 4) begin
            chk("tmo_early_pulse", 64'(tmo_pulse), 64'(0));
            chk("tmo_early_enable", 64'(arb_enable), 64'(0));
         end else begin
            chk("tmo_pulse", 64'(tmo_pulse), 64'(1));
            chk("tmo_idle_enable", 64'(arb_enable), 64'(1));
            chk("tmo_idle_mask", 64'(arb_mask), 64'(0));
         end
      end
      tick();
      #1;
      chk("tmo_pulse_single", 64'(tmo_pulse), 64'(0));
`else
      for (int s = 0; s < 20; s++) tick();
      #1;
      chk("notmo_pulse", 64'(tmo_pulse), 64'(0));
      chk("notmo_still_burst", 64'(arb_enable), 64'(0));
      chk("notmo_mask", 64'(arb_mask), 64'(4'b1101));
`endif
      drain();
      do_init();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/arb_grant_mux.md
ARB_GRANT_MUX -- requirements
Module: arb_grant_mux

Interface
REQ-001 Parameter N, default 4, number of clients, legal range 2..32.
REQ-002 Parameter DW, default 32, payload width per client.
REQ-003 Parameter TMO, default 16, burst stall timeout in cycles, legal range 2..255; used only when ARB_GRANT_MUX_TIMEOUT_EN is defined.
REQ-004 Derived IW = ceil(log2(N)), minimum 1.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 init_n  in  1  synchronous active-low re-initialise.
REQ-008 granted  in  1  arbiter grant-valid flag, registered arbiter output.
REQ-009 grant  in  N  one-hot grant from arbiter.
REQ-010 cl_valid  in  N  per-client beat valid.
REQ-011 cl_last  in  N  per-client end-of-burst marker.
REQ-012 cl_data  in  N*DW  client payloads, client i at bits [i*DW +: DW].
REQ-013 cl_ready  out  N  per-client beat accept.
REQ-014 arb_enable  out  1  enable to arbiter.
REQ-015 arb_mask  out  N  mask to arbiter, 1 = request blocked.
REQ-016 out_valid  out  1, out_ready  in  1  downstream handshake.
REQ-017 out_data  out  DW, out_src  out  IW, out_last  out  1  downstream beat payload, source index, end marker.
REQ-018 err_onehot  out  1  sticky flag: granted high with grant not one-hot.
REQ-019 tmo_pulse  out  1  one-cycle burst-abort indication (timeout build only; tied 0 otherwise).

Function
REQ-020 FSM states IDLE, BURST; reset state IDLE.
REQ-021 IDLE: arb_enable=1, arb_mask=0, cl_ready=0.
REQ-022 IDLE->BURST when granted=1 and grant one-hot; owner index latched from grant in that same cycle.
REQ-023 granted=1 with grant zero or multi-hot: no transition, err_onehot set to 1 and held until reset/init.
REQ-024 BURST: arb_enable=0, arb_mask = all ones except owner bit.
REQ-025 BURST: cl_ready[owner]=1 iff output buffer has a free entry; all other cl_ready bits 0.
REQ-026 A beat transfers when cl_valid[owner] and cl_ready[owner] are both 1; buffer captures cl_data[owner], owner index, cl_last[owner].
REQ-027 BURST->IDLE on the cycle a beat with cl_last=1 transfers; next grant accepted no earlier than the following cycle.
REQ-028 Output buffer: 2-entry skid; out_valid=1 when non-empty; entry removed when out_valid and out_ready; simultaneous push and pop on a full buffer is legal and sustains 1 beat/cycle.
REQ-029 Latency: client beat to out_valid = 1 cycle when buffer is empty.
REQ-030 Beat order at output equals transfer order; no beat is dropped or duplicated.
REQ-031 out_ready low for any duration: cl_ready[owner] drops to 0 once 2 entries are held; no overflow.

Reset
REQ-032 rst_n low: state IDLE, buffer empty, owner 0, err_onehot 0, timeout counter 0; outputs out_valid=0, out_data=0, out_src=0, out_last=0, cl_ready=0, arb_mask=0, arb_enable=0 while asserted, tmo_pulse=0.
REQ-033 init_n low at a rising edge: same values as REQ-032, including mid-burst and with buffered beats (buffered beats discarded).

Configuration
REQ-034 Macro ARB_GRANT_MUX_TIMEOUT_EN defined: in BURST a counter increments each cycle cl_valid[owner]=0, clears on any transfer; reaching TMO forces BURST->IDLE, pulses tmo_pulse for 1 cycle, buffered beats kept.
REQ-035 Macro undefined: no counter logic, tmo_pulse constant 0, BURST exits only via REQ-027.

Structure
REQ-036 Shared package arb_pkg holds state enum (IDLE, BURST) and the IW width function; reused by sibling arbiter blocks.
REQ-037 Sub-module arb_skid_buf (2-entry, parameter width DW+IW+1) implements REQ-028; FSM and mux stay in arb_grant_mux.

Verification
REQ-038 N=4: grant=0100 with granted, client 2 sends 3 beats D0..D2, last on D2, out_ready=1 -> out_src=2, beats D0..D2 on 3 consecutive cycles, arb_mask=1011 during burst, IDLE after D2.
REQ-039 Burst from client 1, out_ready=0 for 5 cycles -> exactly 2 beats buffered, cl_ready[1]=0 thereafter, all beats delivered in order after out_ready=1.
REQ-040 granted=1, grant=0110 -> err_onehot=1, FSM stays IDLE, cl_ready=0.
REQ-041 init_n pulsed mid-burst with 2 beats buffered -> out_valid=0, IDLE, arb_mask=0 next cycle.
REQ-042 Timeout build, TMO=4: owner stalls 4 cycles mid-burst -> tmo_pulse one cycle, IDLE, arb_mask=0.
REQ-043 Back-to-back bursts clients 0 then 3 -> no cycle where two cl_ready bits are high; out_src switches 0->3 only after last of client 0.
